mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the pipeline. It sits between execute and `write_back` and drives the data-memory port with a req/ack handshake. It aligns store data into big-endian byte lanes and right-justifies load data for `write_back` to extend. It registers results into the MEM/WB fields and stalls upstream while a memory access is outstanding, with a timeout guard on the ack.

## Interface
- `ACK_TIMEOUT`, 16: max cycles `dmem_req` stays high without `dmem_ack` before abort (≥2).
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: execute-stage instruction present.
- `in_ctrl` in [0:8]: control bits; [0] reg write, [2] load, [3] store; others pass through.
- `in_alu_out` in [0:31]: ALU result / effective address.
- `in_store_data` in [0:31]: store operand, right-justified.
- `in_dmem_info` in [0:2]: [0] unsigned, [1] word, [2] half (both 0 = byte).
- `in_write_reg` in [0:4]: destination register.
- `stall` out 1: upstream must hold its outputs this cycle.
- `dmem_req` out 1; `dmem_we` out 1; `dmem_addr` out [0:31]; `dmem_wdata` out [0:31]; `dmem_be` out [0:3] (bit 0 = bits [0:7]).
- `dmem_rdata` in [0:31]; `dmem_ack` in 1.
- `wb_valid`, `ctrl` [0:8], `mem_out` [0:31], `alu_out` [0:31], `dmem_info` [0:2], `write_reg` [0:4]: out, registered MEM/WB fields.
- `bus_err` out 1: one-cycle pulse on timeout.
- `misalign_err` out 1: one-cycle pulse (macro only; else tied 0).

## Operation
- States: IDLE, ACCESS.
- IDLE, `in_valid` with neither load nor store: fields registered to outputs next edge, `wb_valid`=1, `mem_out`=0.
- IDLE, `in_valid` with load or store: latch all fields and address; next edge go to ACCESS, `dmem_req`=1, `wb_valid`=0.
- IDLE, `!in_valid`: `wb_valid`=0 next edge.
- ACCESS: `dmem_addr`, `dmem_we`, `dmem_be`, `dmem_wdata` held stable; `stall`=1.
- `dmem_ack` in ACCESS: capture result; next edge output fields load the latched instruction, `wb_valid`=1, `dmem_req`=0, IDLE.
- Store lanes: byte `be`=one-hot by addr[30:31] (00→1000, 11→0001), `wdata`=byte replicated ×4. Half `be`=1100 (addr[30]=0) or 0011, `wdata`=half replicated ×2. Word `be`=1111. `dmem_we`=1.
- Load: `dmem_we`=0, `be` as for store. `mem_out`=selected lane right-justified: byte in [24:31], half in [16:31], upper bits 0. Stores leave `mem_out`=0.
- `stall` = (state == ACCESS); combinational from state only.
- Timeout: a counter increments each ACCESS cycle without ack. When the count reaches `ACK_TIMEOUT`: `dmem_req` drops, `bus_err`=1 for one cycle, `wb_valid`=0, IDLE.
- Ack and timeout in the same cycle: ack wins, no `bus_err`.
- `dmem_ack` in IDLE: ignored.
- `rst` at any time: next edge IDLE, counter 0, `dmem_req`=0, `wb_valid`=0, all output fields 0, errors 0. A late ack after reset is ignored.

## Timing
- Non-memory instruction: 1-cycle latency.
- Memory op: `dmem_req` rises 1 cycle after acceptance. If ack arrives N cycles after `dmem_req` rises (N≥0, same-cycle ack counts as N=0), `wb_valid` rises N+1 cycles after `dmem_req`.
- `stall` is high for every ACCESS cycle, including the ack cycle. The next instruction is accepted the cycle after `wb_valid`.
- Reset values: all outputs 0.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined: a misaligned half (addr[31]=1) or word (addr[30:31]≠00) load/store makes no memory request. `misalign_err` pulses for one cycle the edge after acceptance, `wb_valid`=0, state stays IDLE.
- Undefined: `misalign_err` is tied 0. Misaligned addresses are truncated (half clears addr[31], word clears addr[30:31]) and the access proceeds normally.

## Test plan
- Signed byte load, addr 0x103, rdata 0x11223380, ack after 2 cycles → `be`=0001, `mem_out`=0x00000080, `wb_valid` 3 cycles after `dmem_req`, `stall` high 3 cycles.
- Half store 0x0000BEEF at addr 0x202 → `be`=0011, `wdata`=0xBEEFBEEF, `we`=1; `wb_valid` with `mem_out`=0.
- Back-to-back ALU ops (no load/store) → one result per cycle, `stall` never high, `dmem_req` 0.
- Load with no ack, `ACK_TIMEOUT`=16 → `dmem_req` high 16 cycles, `bus_err` pulse, `wb_valid` 0, next instruction accepted. Repeat with ack on cycle 16 → normal completion, no `bus_err`.
- `rst` asserted mid-ACCESS, then ack after reset → IDLE, `dmem_req` 0 next cycle, ack ignored, outputs 0.
- Word load addr 0x106: with macro → `misalign_err` pulse, no `dmem_req`; without → `dmem_addr`=0x104, `be`=1111.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage with req/ack handshake, ack timeout and optional MEM_MISALIGN_TRAP_EN trap
module mem_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [0:8]  in_ctrl,
  input  logic [0:31] in_alu_out,
  input  logic [0:31] in_store_data,
  input  logic [0:2]  in_dmem_info,
  input  logic [0:4]  in_write_reg,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [0:31] dmem_addr,
  output logic [0:31] dmem_wdata,
  output logic [0:3]  dmem_be,
  input  logic [0:31] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [0:8]  ctrl,
  output logic [0:31] mem_out,
  output logic [0:31] alu_out,
  output logic [0:2]  dmem_info,
  output logic [0:4]  write_reg,
  output logic        bus_err,
  output logic        misalign_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:8]    lctrl_q, lctrl_d, ctrl_q, ctrl_d;
  logic [0:31]   lalu_q, lalu_d, alu_out_q, alu_out_d, mem_out_q, mem_out_d;
  logic [0:2]    linfo_q, linfo_d, dmem_info_q, dmem_info_d;
  logic [0:4]    lreg_q, lreg_d, write_reg_q, write_reg_d;
  logic [0:31]   addr_q, addr_d, wdata_q, wdata_d;
  logic [0:3]    be_q, be_d;
  logic          we_q, we_d, wb_valid_q, wb_valid_d, bus_err_q, bus_err_d, mis_q, mis_d;
  logic          mem_op, is_word, is_half, rword, rhalf, trap;
  logic [1:0]    off, lo;
  logic [0:31]   addr_al, wdata_n, load_val;
  logic [0:3]    be_n;
  always_comb begin
    mem_op   = in_ctrl[2] | in_ctrl[3];
    is_word  = in_dmem_info[1];
    is_half  = !in_dmem_info[1] && in_dmem_info[2];
    off      = in_alu_out[30:31];
    addr_al  = is_word ? {in_alu_out[0:29], 2'b00} : is_half ? {in_alu_out[0:30], 1'b0} : in_alu_out;
    be_n     = is_word ? 4'b1111 : is_half ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1000 >> off;
    wdata_n  = is_word ? in_store_data : is_half ? {2{in_store_data[16:31]}} : {4{in_store_data[24:31]}};
    lo       = addr_q[30:31];
    rword    = linfo_q[1];
    rhalf    = !linfo_q[1] && linfo_q[2];
    load_val = rword ? dmem_rdata : rhalf ? {16'b0, dmem_rdata[16*lo[1] +: 16]} : {24'b0, dmem_rdata[8*lo +: 8]};
`ifdef MEM_MISALIGN_TRAP_EN
    trap = (is_word && off != 2'b00) || (is_half && off[0]);
`else
    trap = 1'b0;
`endif
  end
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lctrl_d     = lctrl_q;
    lalu_d      = lalu_q;
    linfo_d     = linfo_q;
    lreg_d      = lreg_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    ctrl_d      = ctrl_q;
    alu_out_d   = alu_out_q;
    mem_out_d   = mem_out_q;
    dmem_info_d = dmem_info_q;
    write_reg_d = write_reg_q;
    wb_valid_d  = 1'b0;
    bus_err_d   = 1'b0;
    mis_d       = 1'b0;
    if (state_q == IDLE) begin
      if (in_valid && !mem_op) begin
        wb_valid_d  = 1'b1;
        ctrl_d      = in_ctrl;
        alu_out_d   = in_alu_out;
        mem_out_d   = '0;
        dmem_info_d = in_dmem_info;
        write_reg_d = in_write_reg;
      end else if (in_valid && trap) begin
        mis_d = 1'b1;
      end else if (in_valid) begin
        state_d = ACCESS;
        cnt_d   = '0;
        lctrl_d = in_ctrl;
        lalu_d  = in_alu_out;
        linfo_d = in_dmem_info;
        lreg_d  = in_write_reg;
        addr_d  = addr_al;
        we_d    = in_ctrl[3];
        be_d    = be_n;
        wdata_d = wdata_n;
      end
    end else if (dmem_ack) begin
      state_d     = IDLE;
      wb_valid_d  = 1'b1;
      ctrl_d      = lctrl_q;
      alu_out_d   = lalu_q;
      mem_out_d   = lctrl_q[2] ? load_val : '0;
      dmem_info_d = linfo_q;
      write_reg_d = lreg_q;
    end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
      state_d   = IDLE;
      bus_err_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lctrl_q     <= '0;
      lalu_q      <= '0;
      linfo_q     <= '0;
      lreg_q      <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      ctrl_q      <= '0;
      alu_out_q   <= '0;
      mem_out_q   <= '0;
      dmem_info_q <= '0;
      write_reg_q <= '0;
      wb_valid_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lctrl_q     <= lctrl_d;
      lalu_q      <= lalu_d;
      linfo_q     <= linfo_d;
      lreg_q      <= lreg_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      ctrl_q      <= ctrl_d;
      alu_out_q   <= alu_out_d;
      mem_out_q   <= mem_out_d;
      dmem_info_q <= dmem_info_d;
      write_reg_q <= write_reg_d;
      wb_valid_q  <= wb_valid_d;
      bus_err_q   <= bus_err_d;
      mis_q       <= mis_d;
    end
  end
  assign stall        = state_q == ACCESS;
  assign dmem_req     = state_q == ACCESS;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign wb_valid     = wb_valid_q;
  assign ctrl         = ctrl_q;
  assign mem_out      = mem_out_q;
  assign alu_out      = alu_out_q;
  assign dmem_info    = dmem_info_q;
  assign write_reg    = write_reg_q;
  assign bus_err      = bus_err_q;
  assign misalign_err = mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, dmem_ack;
  logic [0:8]  in_ctrl;
  logic [0:31] in_alu_out, in_store_data, dmem_rdata;
  logic [0:2]  in_dmem_info;
  logic [0:4]  in_write_reg;
  logic        stall, dmem_req, dmem_we, wb_valid, bus_err, misalign_err;
  logic [0:31] dmem_addr, dmem_wdata, mem_out, alu_out;
  logic [0:3]  dmem_be;
  logic [0:8]  ctrl;
  logic [0:2]  dmem_info;
  logic [0:4]  write_reg;
  int passed = 0;
  int total = 0;
  mem_stage #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_alu_out(in_alu_out),
    .in_store_data(in_store_data), .in_dmem_info(in_dmem_info), .in_write_reg(in_write_reg),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .ctrl(ctrl), .mem_out(mem_out), .alu_out(alu_out),
    .dmem_info(dmem_info), .write_reg(write_reg), .bus_err(bus_err), .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic ld, input logic st, input logic [0:2] info, input logic [0:31] a,
                       input logic [0:31] sd, input logic [0:4] rd);
    in_valid = 1'b1;
    in_ctrl = '0;
    in_ctrl[0] = ld;
    in_ctrl[2] = ld;
    in_ctrl[3] = st;
    in_ctrl[8] = 1'b1;
    in_dmem_info = info;
    in_alu_out = a;
    in_store_data = sd;
    in_write_reg = rd;
  endtask
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    in_ctrl = '0; in_alu_out = '0; in_store_data = '0; in_dmem_info = '0; in_write_reg = '0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({stall, dmem_req, dmem_we, wb_valid, bus_err, misalign_err} !== 6'b0 || dmem_addr !== 0 ||
        dmem_wdata !== 0 || dmem_be !== 0 || ctrl !== 0 || mem_out !== 0 || alu_out !== 0 ||
        dmem_info !== 0 || write_reg !== 0)
      $display("FAIL reset: req=%b stall=%b wb=%b addr=%h mem_out=%h expected all zero", dmem_req, stall, wb_valid, dmem_addr, mem_out);
    else passed++;
  endtask
  task automatic test_byte_load();
    int stalls = 0;
    issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd7);
    tick();
    in_valid = 1'b0;
    total++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_be !== 4'b0001 || dmem_addr !== 32'h103 || wb_valid !== 1'b0)
      $display("FAIL byte_load_req: req=%b we=%b be=%b addr=%h wb=%b expected 1 0 0001 103 0", dmem_req, dmem_we, dmem_be, dmem_addr, wb_valid);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'h11223380; end
      if (stall) stalls++;
      tick();
    end
    dmem_ack = 1'b0;
    total++;
    if (stalls != 3) $display("FAIL byte_load_stall: %0d stall cycles expected 3", stalls);
    else passed++;
    total++;
    if (wb_valid !== 1'b1 || mem_out !== 32'h80 || dmem_req !== 1'b0 || stall !== 1'b0 || write_reg !== 5'd7 || alu_out !== 32'h103)
      $display("FAIL byte_load_wb: wb=%b mem_out=%h req=%b rd=%0d expected 1 00000080 0 7", wb_valid, mem_out, dmem_req, write_reg);
    else passed++;
  endtask
  task automatic test_half_store();
    logic [0:8] exp_ctrl;
    issue(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000BEEF, 5'd3);
    exp_ctrl = in_ctrl;
    tick();
    in_valid = 1'b0;
    total++;
    if (dmem_be !== 4'b0011 || dmem_wdata !== 32'hBEEFBEEF || dmem_we !== 1'b1 || dmem_req !== 1'b1)
      $display("FAIL half_store_req: be=%b wdata=%h we=%b req=%b expected 0011 beefbeef 1 1", dmem_be, dmem_wdata, dmem_we, dmem_req);
    else passed++;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    tick();
    dmem_ack = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || mem_out !== 32'h0 || ctrl !== exp_ctrl || dmem_info !== 3'b001)
      $display("FAIL half_store_wb: wb=%b mem_out=%h ctrl=%b expected 1 00000000 %b", wb_valid, mem_out, ctrl, exp_ctrl);
    else passed++;
  endtask
  task automatic test_back_to_back();
    logic [0:31] a [4] = '{32'h1, 32'hA5A5_0000, 32'hFFFF_FFFF, 32'h1234_5678};
    int bad = 0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b0, 3'b010, a[i], 32'h0, 5'(i + 10));
      in_ctrl[0] = 1'b1;
      tick();
      if (wb_valid !== 1'b1 || alu_out !== a[i] || write_reg !== 5'(i + 10) || mem_out !== 0 || stall || dmem_req) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL back_to_back: %0d bad results expected 0", bad);
    else passed++;
    in_valid = 1'b0;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    total++;
    if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || stall !== 1'b0)
      $display("FAIL idle_ack: wb=%b req=%b stall=%b expected 0 0 0", wb_valid, dmem_req, stall);
    else passed++;
  endtask
  task automatic test_timeout();
    int reqs = 0;
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && dmem_req; i++) begin
      reqs++;
      tick();
    end
    total++;
    if (reqs != 16) $display("FAIL timeout_len: req high %0d cycles expected 16", reqs);
    else passed++;
    total++;
    if (bus_err !== 1'b1 || wb_valid !== 1'b0 || stall !== 1'b0)
      $display("FAIL timeout_err: bus_err=%b wb=%b stall=%b expected 1 0 0", bus_err, wb_valid, stall);
    else passed++;
    issue(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd9);
    tick();
    in_valid = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || alu_out !== 32'h55 || bus_err !== 1'b0)
      $display("FAIL timeout_next: wb=%b alu=%h bus_err=%b expected 1 00000055 0", wb_valid, alu_out, bus_err);
    else passed++;
  endtask
  task automatic test_ack16();
    issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd2);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_ack = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || bus_err !== 1'b0 || mem_out !== 32'hDEADBEEF || dmem_req !== 1'b0)
      $display("FAIL ack16: wb=%b bus_err=%b mem_out=%h req=%b expected 1 0 deadbeef 0", wb_valid, bus_err, mem_out, dmem_req);
    else passed++;
  endtask
  task automatic test_reset_mid();
    issue(1'b1, 1'b0, 3'b000, 32'h500, 32'h0, 5'd4);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    total++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0 || mem_out !== 0 || alu_out !== 0 || ctrl !== 0 || write_reg !== 0)
      $display("FAIL reset_mid: req=%b stall=%b wb=%b mem_out=%h alu=%h expected all 0", dmem_req, stall, wb_valid, mem_out, alu_out);
    else passed++;
    tick();
    dmem_ack = 1'b0;
    total++;
    if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || mem_out !== 0 || bus_err !== 1'b0)
      $display("FAIL late_ack: req=%b wb=%b mem_out=%h bus_err=%b expected 0 0 0 0", dmem_req, wb_valid, mem_out, bus_err);
    else passed++;
  endtask
  task automatic test_misalign();
    issue(1'b1, 1'b0, 3'b010, 32'h106, 32'h0, 5'd6);
    tick();
    in_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    total++;
    if (misalign_err !== 1'b1 || dmem_req !== 1'b0 || wb_valid !== 1'b0 || stall !== 1'b0)
      $display("FAIL misalign_trap: err=%b req=%b wb=%b expected 1 0 0", misalign_err, dmem_req, wb_valid);
    else passed++;
    tick();
    total++;
    if (misalign_err !== 1'b0 || dmem_req !== 1'b0)
      $display("FAIL misalign_pulse: err=%b req=%b expected 0 0", misalign_err, dmem_req);
    else passed++;
`else
    total++;
    if (dmem_addr !== 32'h104 || dmem_be !== 4'b1111 || dmem_req !== 1'b1 || misalign_err !== 1'b0)
      $display("FAIL misalign_trunc: addr=%h be=%b req=%b err=%b expected 00000104 1111 1 0", dmem_addr, dmem_be, dmem_req, misalign_err);
    else passed++;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_ack = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || mem_out !== 32'hCAFEF00D)
      $display("FAIL misalign_load: wb=%b mem_out=%h expected 1 cafef00d", wb_valid, mem_out);
    else passed++;
`endif
  endtask
  task automatic test_half_load();
    issue(1'b1, 1'b0, 3'b101, 32'h700, 32'h0, 5'd5);
    tick();
    in_valid = 1'b0;
    total++;
    if (dmem_be !== 4'b1100 || dmem_we !== 1'b0)
      $display("FAIL half_load_be: be=%b we=%b expected 1100 0", dmem_be, dmem_we);
    else passed++;
    dmem_ack = 1'b1; dmem_rdata = 32'h8765_4321;
    tick();
    dmem_ack = 1'b0;
    total++;
    if (mem_out !== 32'h0000_8765 || dmem_info !== 3'b101)
      $display("FAIL half_load_data: mem_out=%h info=%b expected 00008765 101", mem_out, dmem_info);
    else passed++;
  endtask
  task automatic test_byte_store();
    issue(1'b0, 1'b1, 3'b000, 32'h801, 32'h0000_00C3, 5'd0);
    tick();
    in_valid = 1'b0;
    total++;
    if (dmem_be !== 4'b0100 || dmem_wdata !== 32'hC3C3C3C3 || dmem_we !== 1'b1)
      $display("FAIL byte_store: be=%b wdata=%h we=%b expected 0100 c3c3c3c3 1", dmem_be, dmem_wdata, dmem_we);
    else passed++;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    tick();
  endtask
  initial begin
    test_reset();
    test_byte_load();
    test_half_store();
    test_back_to_back();
    test_timeout();
    test_ack16();
    test_half_load();
    test_byte_store();
    test_reset_mid();
    test_misalign();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
